// File: rtl/rot_enc_pkg.sv
// rot_enc_pkg: index modes and host write addresses shared by the encoder counter
package rot_enc_pkg;
  typedef enum logic [1:0] {CAPTURE, ZERO_ONCE, ZERO_ALWAYS, RSVD} idx_mode_t;
  localparam logic [1:0] WA_PRESET = 2'd0;
  localparam logic [1:0] WA_MODE = 2'd1;
  localparam logic [1:0] WA_CLR = 2'd2;
endpackage

// File: rtl/rot_enc_idx_ch.sv
// rot_enc_idx_ch: one encoder channel with sync, debounce, x4 decode, counter and index handling
module rot_enc_idx_ch
  import rot_enc_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int FLT_W = 7
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             sclr,
  input  logic             ena,
  input  logic             dir,
  input  logic             a,
  input  logic             b,
  input  logic             z,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [CNT_W-1:0] wr_data,
  output logic [CNT_W-1:0] counter,
  output logic [CNT_W-1:0] z_pos,
  output logic             z_flag,
  output logic             error,
  output logic             ovf,
  output logic             ready
);
  localparam logic [FLT_W-1:0] F_MAX = '1;
  localparam logic [FLT_W-1:0] F_MID = FLT_W'(1) << (FLT_W - 1);
  localparam logic [CNT_W-1:0] C_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] C_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic dir_q, dir_d;
  logic [FLT_W-1:0] flt_q [3];
  logic [FLT_W-1:0] flt_d [3];
  logic [2:0] fout_q, fout_d, set_q, set_d;
  logic [1:0] ab_q, ab_d, ab_cur, chg;
  logic zp_q, zp_d, rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, zpos_q, zpos_d, delta;
  logic zflag_q, zflag_d, err_q, err_d, ovf_q, ovf_d, armed_q, armed_d;
  idx_mode_t mode_q, mode_d;
  logic clr, step, up, idx, zero, wp, wm, wc;
  always_comb begin
    sync1_d = {dir, z, b, a};
    sync2_d = sync1_q;
    dir_d = sync2_q[3];
    clr = sclr | (sync2_q[3] ^ dir_q);
    for (int i = 0; i < 3; i++) begin
      flt_d[i] = sync2_q[i] ? (flt_q[i] == F_MAX ? F_MAX : flt_q[i] + 1'b1)
                            : (flt_q[i] == '0 ? '0 : flt_q[i] - 1'b1);
      fout_d[i] = flt_d[i] == F_MAX ? 1'b1 : flt_d[i] == '0 ? 1'b0 : fout_q[i];
      set_d[i] = set_q[i] | flt_d[i] == F_MAX | flt_d[i] == '0;
    end
    rdy_d = &set_q;
    ab_cur = {fout_q[0], fout_q[1]};
    ab_d = ab_cur;
    zp_d = fout_q[2];
    chg = ab_q ^ ab_cur;
    step = rdy_q & ena & (^chg);
    up = ab_q[1] ^ ab_cur[0] ^ dir_q;
    delta = step ? {{(CNT_W-1){~up}}, 1'b1} : '0;
    idx = rdy_q & zp_q & ~fout_q[2];
    zero = idx & (mode_q == ZERO_ALWAYS | (mode_q == ZERO_ONCE & armed_q));
    wp = wr_en & wr_addr == WA_PRESET;
    wm = wr_en & wr_addr == WA_MODE;
    wc = wr_en & wr_addr == WA_CLR;
    cnt_d = wp ? wr_data : zero ? delta : cnt_q + delta;
    ovf_d = ~(wp | wc) & (ovf_q | (step & ~zero & cnt_q == (up ? C_MAX : C_MIN)));
    err_d = ~(wp | wc) & (err_q | (rdy_q & (&chg)));
    zpos_d = idx ? cnt_q : zpos_q;
    zflag_d = idx | (zflag_q & ~wc);
    mode_d = wm ? idx_mode_t'(wr_data[1:0]) : mode_q;
    armed_d = wm | (armed_q & ~(zero & mode_q == ZERO_ONCE));
    if (clr) begin
      for (int i = 0; i < 3; i++) flt_d[i] = F_MID;
      fout_d = '0;
      set_d = '0;
      rdy_d = 1'b0;
      ab_d = '0;
      zp_d = 1'b0;
      cnt_d = '0;
      zpos_d = '1;
      zflag_d = 1'b0;
      err_d = 1'b0;
      ovf_d = 1'b0;
      mode_d = sclr ? CAPTURE : mode_q;
      armed_d = sclr | armed_q;
    end
  end
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      dir_q <= 1'b0;
      flt_q <= '{default: F_MID};
      fout_q <= '0;
      set_q <= '0;
      rdy_q <= 1'b0;
      ab_q <= '0;
      zp_q <= 1'b0;
      cnt_q <= '0;
      zpos_q <= '1;
      zflag_q <= 1'b0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
      mode_q <= CAPTURE;
      armed_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dir_q <= dir_d;
      flt_q <= flt_d;
      fout_q <= fout_d;
      set_q <= set_d;
      rdy_q <= rdy_d;
      ab_q <= ab_d;
      zp_q <= zp_d;
      cnt_q <= cnt_d;
      zpos_q <= zpos_d;
      zflag_q <= zflag_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
      mode_q <= mode_d;
      armed_q <= armed_d;
    end
  end
  assign counter = cnt_q;
  assign z_pos = zpos_q;
  assign z_flag = zflag_q;
  assign error = err_q;
  assign ovf = ovf_q;
  assign ready = rdy_q;
endmodule

// File: rtl/rot_enc_idx_multi.sv
// rot_enc_idx_multi: multi-channel quadrature counter with index handling and shared host write port
module rot_enc_idx_multi
  import rot_enc_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int CNT_W = 32,
  parameter int FLT_W = 7,
  parameter int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      aclr_n,
  input  logic                      sclr,
  input  logic [CHANNELS-1:0]       ena,
  input  logic [CHANNELS-1:0]       dir,
  input  logic [CHANNELS-1:0]       A,
  input  logic [CHANNELS-1:0]       B,
  input  logic [CHANNELS-1:0]       Z,
  output logic [CHANNELS*CNT_W-1:0] counter,
  output logic [CHANNELS*CNT_W-1:0] Z_pos,
  output logic [CHANNELS-1:0]       Z_flag,
  output logic [CHANNELS-1:0]       error,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       ready,
  input  logic                      write,
  input  logic [CH_W-1:0]           wr_ch,
  input  logic [1:0]                wr_addr,
  input  logic [CNT_W-1:0]          wr_data
);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    rot_enc_idx_ch #(.CNT_W(CNT_W), .FLT_W(FLT_W)) u_ch (
      .clock  (clock),
      .aclr_n (aclr_n),
      .sclr   (sclr),
      .ena    (ena[c]),
      .dir    (dir[c]),
      .a      (A[c]),
      .b      (B[c]),
      .z      (Z[c]),
      .wr_en  (write & (wr_ch == CH_W'(c))),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .counter(counter[c*CNT_W +: CNT_W]),
      .z_pos  (Z_pos[c*CNT_W +: CNT_W]),
      .z_flag (Z_flag[c]),
      .error  (error[c]),
      .ovf    (ovf[c]),
      .ready  (ready[c])
    );
  end
endmodule

// File: tb/tb_rot_enc_idx_multi.sv
// tb_rot_enc_idx_multi: directed bench with a per-channel behavioural model and literal spot checks
module tb_rot_enc_idx_multi;
  localparam int CH = 2;
  localparam int CW = 8;
  localparam int FW = 2;
  localparam int HOLD = 10;
  logic clock = 1'b0;
  logic aclr_n, sclr, write;
  logic [CH-1:0] ena, dir, A, B, Z;
  logic [0:0] wr_ch;
  logic [1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic [CH*CW-1:0] counter, Z_pos;
  logic [CH-1:0] Z_flag, error, ovf, ready;
  int m_cnt [CH];
  int m_zpos [CH];
  int m_mode [CH];
  bit m_zflag [CH];
  bit m_err [CH];
  bit m_ovf [CH];
  bit m_rdy [CH];
  bit m_armed [CH];
  logic [1:0] m_ab [CH];
  logic [1:0] gseq [4];
  bit chk;
  int n_chk, n_pass;
  always #5 clock = ~clock;
  rot_enc_idx_multi #(.CHANNELS(CH), .CNT_W(CW), .FLT_W(FW)) dut (
    .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .ena(ena), .dir(dir),
    .A(A), .B(B), .Z(Z), .counter(counter), .Z_pos(Z_pos), .Z_flag(Z_flag),
    .error(error), .ovf(ovf), .ready(ready), .write(write), .wr_ch(wr_ch),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );
  task automatic check(string nm, int c, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s ch%0d got %0d want %0d at %0t", nm, c, act, exp, $time);
  endtask
  function automatic int cnt_of(int c);
    return int'($signed(counter[c*CW +: CW]));
  endfunction
  function automatic int zp_of(int c);
    return int'($signed(Z_pos[c*CW +: CW]));
  endfunction
  function automatic int gpos(logic [1:0] ab);
    return ab == 2'b00 ? 0 : ab == 2'b01 ? 1 : ab == 2'b11 ? 2 : 3;
  endfunction
  always @(negedge clock) begin
    if (chk) begin
      for (int c = 0; c < CH; c++) begin
        check("cnt", c, cnt_of(c), m_cnt[c]);
        check("zpos", c, zp_of(c), m_zpos[c]);
        check("zflag", c, int'(Z_flag[c]), int'(m_zflag[c]));
        check("err", c, int'(error[c]), int'(m_err[c]));
        check("ovf", c, int'(ovf[c]), int'(m_ovf[c]));
        check("rdy", c, int'(ready[c]), int'(m_rdy[c]));
      end
    end
  end
  task automatic m_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0;
      m_zpos[c] = -1;
      m_zflag[c] = 0;
      m_err[c] = 0;
      m_ovf[c] = 0;
      m_rdy[c] = 1;
      m_armed[c] = 1;
      m_mode[c] = 0;
      m_ab[c] = {A[c], B[c]};
    end
  endtask
  task automatic m_pins(int c, logic [1:0] nab);
    int d;
    if ((m_ab[c] ^ nab) == 2'b11) m_err[c] = 1;
    else if (nab != m_ab[c] && ena[c]) begin
      d = ((gpos(nab) - gpos(m_ab[c]) + 4) % 4 == 1) ? 1 : -1;
      if (dir[c]) d = -d;
      m_cnt[c] += d;
      if (m_cnt[c] > 2**(CW-1) - 1) begin m_cnt[c] -= 2**CW; m_ovf[c] = 1; end
      if (m_cnt[c] < -(2**(CW-1))) begin m_cnt[c] += 2**CW; m_ovf[c] = 1; end
    end
    m_ab[c] = nab;
  endtask
  task automatic m_index(int c);
    m_zpos[c] = m_cnt[c];
    m_zflag[c] = 1;
    if (m_mode[c] == 2 || (m_mode[c] == 1 && m_armed[c])) begin
      m_cnt[c] = 0;
      if (m_mode[c] == 1) m_armed[c] = 0;
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic settle_chk();
    tick(HOLD);
    chk = 1;
    tick(2);
  endtask
  task automatic drive(int c, logic [1:0] ab, logic zz);
    chk = 0;
    if (Z[c] && !zz) m_index(c);
    m_pins(c, ab);
    A[c] = ab[1];
    B[c] = ab[0];
    Z[c] = zz;
    settle_chk();
  endtask
  task automatic qstep(int c, int n);
    int p;
    repeat (n) begin
      p = gpos({A[c], B[c]});
      drive(c, gseq[(p + 1) % 4], Z[c]);
    end
  endtask
  task automatic zpulse(int c);
    drive(c, {A[c], B[c]}, 1'b1);
    drive(c, {A[c], B[c]}, 1'b0);
  endtask
  task automatic wr(int c, logic [1:0] addr, logic [CW-1:0] data);
    chk = 0;
    write = 1;
    wr_ch = c[0];
    wr_addr = addr;
    wr_data = data;
    tick(1);
    write = 0;
    if (addr == 2'd0) begin
      m_cnt[c] = int'($signed(data));
      m_ovf[c] = 0;
      m_err[c] = 0;
    end else if (addr == 2'd1) begin
      m_mode[c] = int'(data[1:0]);
      m_armed[c] = 1;
    end else if (addr == 2'd2) begin
      m_zflag[c] = 0;
      m_err[c] = 0;
      m_ovf[c] = 0;
    end
    settle_chk();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int n;
    gseq = '{2'b00, 2'b01, 2'b11, 2'b10};
    aclr_n = 0; sclr = 0; write = 0; wr_ch = 0; wr_addr = 0; wr_data = 0;
    ena = '1; dir = 2'b10; A = '0; B = '0; Z = '0; chk = 0;
    tick(3);
    for (int c = 0; c < CH; c++) begin
      check("rst_cnt", c, cnt_of(c), 0);
      check("rst_zpos", c, zp_of(c), -1);
      check("rst_flags", c, int'({Z_flag[c], error[c], ovf[c]}), 0);
      check("rst_rdy", c, int'(ready[c]), 0);
    end
    aclr_n = 1;
    m_reset();
    tick(12);
    chk = 1;
    tick(2);
    qstep(0, 10);
    check("fwd_cnt0", 0, cnt_of(0), 10);
    check("fwd_rdy0", 0, int'(ready[0]), 1);
    check("fwd_cnt1", 1, cnt_of(1), 0);
    qstep(1, 10);
    check("rev_cnt1", 1, cnt_of(1), -10);
    wr(0, 2'd0, 8'd37);
    zpulse(0);
    check("cap_zpos", 0, zp_of(0), 37);
    check("cap_zflag", 0, int'(Z_flag[0]), 1);
    check("cap_cnt", 0, cnt_of(0), 37);
    wr(0, 2'd2, 8'd0);
    check("clr_zflag", 0, int'(Z_flag[0]), 0);
    wr(0, 2'd1, 8'd1);
    wr(0, 2'd0, 8'd50);
    zpulse(0);
    check("once_cnt", 0, cnt_of(0), 0);
    check("once_zpos", 0, zp_of(0), 50);
    qstep(0, 4);
    zpulse(0);
    check("once2_zpos", 0, zp_of(0), 4);
    check("once2_cnt", 0, cnt_of(0), 4);
    qstep(0, 1);
    check("once3_cnt", 0, cnt_of(0), 5);
    wr(0, 2'd1, 8'd0);
    wr(0, 2'd0, 8'd127);
    qstep(0, 1);
    check("wrap_cnt", 0, cnt_of(0), -128);
    check("wrap_ovf", 0, int'(ovf[0]), 1);
    wr(0, 2'd0, 8'd5);
    check("pre_ovf", 0, int'(ovf[0]), 0);
    check("pre_cnt", 0, cnt_of(0), 5);
    wr(0, 2'd3, 8'h55);
    drive(0, ~{A[0], B[0]}, Z[0]);
    check("err_set", 0, int'(error[0]), 1);
    check("err_cnt", 0, cnt_of(0), 5);
    chk = 0;
    dir[0] = ~dir[0];
    m_cnt[0] = 0; m_zpos[0] = -1; m_zflag[0] = 0; m_err[0] = 0; m_ovf[0] = 0;
    n = 0;
    while (ready[0] && n < 8) begin tick(1); n++; end
    check("rdy_drop", 0, int'(ready[0]), 0);
    n = 0;
    while (!ready[0] && n < 2**FW + 4) begin tick(1); n++; end
    check("rdy_back", 0, int'(ready[0]), 1);
    settle_chk();
    check("dir_cnt", 0, cnt_of(0), 0);
    check("dir_zpos", 0, zp_of(0), -1);
    chk = 0;
    A[0] = ~A[0];
    tick(2);
    A[0] = ~A[0];
    settle_chk();
    check("glitch_cnt", 0, cnt_of(0), 0);
    qstep(0, 1);
    check("inv_cnt", 0, cnt_of(0), -1);
    wr(1, 2'd1, 8'd2);
    zpulse(1);
    check("alw_zpos", 1, zp_of(1), -10);
    qstep(1, 2);
    zpulse(1);
    check("alw2_zpos", 1, zp_of(1), -2);
    check("alw2_cnt", 1, cnt_of(1), 0);
    chk = 0;
    sclr = 1;
    tick(1);
    sclr = 0;
    m_reset();
    settle_chk();
    check("sclr_cnt1", 1, cnt_of(1), 0);
    qstep(0, 3);
    chk = 0;
    A[0] = ~A[0];
    tick(3);
    #2 aclr_n = 0;
    #1;
    for (int c = 0; c < CH; c++) begin
      check("aclr_cnt", c, cnt_of(c), 0);
      check("aclr_zpos", c, zp_of(c), -1);
      check("aclr_flags", c, int'({Z_flag[c], error[c], ovf[c]}), 0);
      check("aclr_rdy", c, int'(ready[c]), 0);
    end
    tick(2);
    aclr_n = 1;
    m_reset();
    tick(12);
    chk = 1;
    tick(2);
    chk = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
